rsr_stream_ctrl: RTL and testbench
==================================

Name: rsr_stream_ctrl

Overview:
Sequencer for the non-resettable, free-running serial right-shift register (DEPTH stages, ports si/so, shifts every clk).
- Accepts parallel words over a valid/ready handshake and serialises them MSB-first onto the register input.
- Tracks which bits in flight are real, deserialises the register output back into words, and flags completion.
- Sits between a word-level producer/consumer and the shift-register datapath.

Parameters:
WIDTH, 8, bits per word; must satisfy WIDTH >= DEPTH and WIDTH >= 2
DEPTH, 4, stages in the attached shift register (bit sampled on si at edge t is on so after edge t+DEPTH-1)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  producer has a word on in_data
in_ready  output  1  controller can accept a word this cycle
in_data  input  WIDTH  word to serialise
sr_si  output  1  drives the shift register si
sr_so  input  1  from the shift register so
out_valid  output  1  one-cycle pulse: out_data holds a complete received word
out_data  output  WIDTH  deserialised word, held until the next out_valid
busy  output  1  high while a word is being sent or any real bit is in flight

Behaviour:
- Reset (async assert, sync release): state IDLE, bit counter 0, tx/rx registers 0, marker pipeline cleared. out_valid=0, out_data=0, sr_si=0, busy=0, in_ready=1.
- Transmit FSM, states IDLE and SEND:
  - IDLE: in_ready=1. On in_valid at edge a, load tx_reg<=in_data, cnt<=0, go SEND.
  - SEND: sr_si=tx_reg[WIDTH-1]; each edge shifts tx_reg left and increments cnt.
  - At cnt==WIDTH-1, in_ready=1. If in_valid, reload and stay in SEND (zero-gap streaming); otherwise go IDLE.
  - in_ready=0 for all other SEND cycles. in_data is ignored when in_ready=0.
- sr_si=0 whenever not in SEND (idle filler bits).
- Marker pipeline (DEPTH bits) shifts every edge, with input = (state==SEND). It is aligned so that mark[DEPTH-1] is high exactly when sr_so carries a real bit.
- Receive side:
  - On an edge with mark[DEPTH-1]=1: rx_reg<=(rx_reg<<1)|sr_so and rcnt increments.
  - When rcnt reaches WIDTH-1 on such an edge: out_data<=completed word, out_valid=1 for the next cycle, rcnt<=0.
- Latency: word accepted at edge a drives bit i on sr_si for edges a+1+i and is captured at edge a+1+i+DEPTH. out_valid is high in the cycle after edge a+WIDTH+DEPTH (12 cycles for defaults).
- Throughput: one word per WIDTH cycles when streaming. At most 2 words are in flight.
- No output backpressure: the consumer must take out_data on the out_valid pulse.
- busy = (state==SEND) | (|mark) | (rcnt!=0).
- Reset mid-operation: all control state is cleared. Stale bits left in the external register are ignored because markers are cleared, so no spurious out_valid.
- Simultaneous last-bit capture of word N and acceptance of word N+1 is legal. Both sides operate independently.

Optional Feature:
RSR_CHECK_EN
- With the macro defined: adds output port err (1 bit, reset 0).
  - Each accepted word is pushed into a 2-entry expected-word FIFO.
  - On each out_valid, the head entry is popped and compared with out_data. err pulses high in the same cycle as out_valid on mismatch.
- Without the macro: no err port, no FIFO, identical timing otherwise.

Test Plan:
- Reset then single word 0xCA -> sr_si shows 1,1,0,0,1,0,1,0 over edges a+1..a+8. out_valid is a single pulse 12 cycles after accept with out_data=0xCA. busy then drops.
- Back-to-back 0xCA then 0x35 with in_valid held -> in_ready high only in IDLE and on the last bit. sr_si has no gap. out_valid pulses 8 cycles apart with 0xCA then 0x35.
- in_valid low for 20 cycles after reset -> sr_si=0, out_valid=0, busy=0, in_ready=1 throughout.
- rst_n pulsed low at bit 3 of word 0xFF -> outputs return to reset values immediately. No out_valid ever follows. Next word 0x81 round-trips correctly.
- in_valid raised mid-SEND (cnt=2) with 0x55 -> not accepted until the cnt==WIDTH-1 cycle. in_data changes before acceptance are ignored.
- With RSR_CHECK_EN, the bench register model flips the 4th bit of word 0xCA -> out_data=0xDA and err=1 coincident with out_valid. With a clean model, err stays 0.

Source files
------------

// File: rtl/rsr_stream_ctrl_if.sv
// Word/serial bus for rsr_stream_ctrl: producer handshake, shift-register taps, receive side.
// Handshake: a word moves on a rising edge where in_valid && in_ready; in_data is ignored otherwise.
interface rsr_stream_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             sr_si;
  logic             sr_so;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             busy;
  logic             dbg_state;

  modport master (
    output in_valid, in_data, sr_so,
    input  in_ready, sr_si, out_valid, out_data, busy, dbg_state
  );

  modport slave (
    input  in_valid, in_data, sr_so,
    output in_ready, sr_si, out_valid, out_data, busy, dbg_state
  );
endinterface

// File: rtl/rsr_stream_ctrl.sv
// Serialises words MSB-first into an external free-running shift register and rebuilds them from its output.
// Define RSR_CHECK_EN to add the err port backed by a 2-entry expected-word FIFO.
module rsr_stream_ctrl #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input logic              clk,
  input logic              rst_n,
  rsr_stream_ctrl_if.slave bus
`ifdef RSR_CHECK_EN
  ,
  output logic             err
`endif
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] tx_reg;
  logic             in_ready_q;
  logic             sr_si_q;
  logic [DEPTH-1:0] mark;
  logic [WIDTH-1:0] rx_reg;
  logic [CW-1:0]    rcnt;
  logic             out_valid_q;
  logic [WIDTH-1:0] out_data_q;
  logic [WIDTH-1:0] rx_next;
  logic             last_bit;
  logic             rx_last;

  assign last_bit = (cnt == CW'(WIDTH - 1));
  assign rx_next  = {rx_reg[WIDTH-2:0], bus.sr_so};
  assign rx_last  = mark[DEPTH-1] && (rcnt == CW'(WIDTH - 1));

  // sr_si and in_ready are registered copies of what tx_reg/cnt will show after the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      tx_reg     <= '0;
      in_ready_q <= 1'b1;
      sr_si_q    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.in_valid) begin
            state      <= SEND;
            tx_reg     <= bus.in_data;
            cnt        <= '0;
            in_ready_q <= 1'b0;
            sr_si_q    <= bus.in_data[WIDTH-1];
          end
        end
        SEND: begin
          if (last_bit) begin
            if (bus.in_valid) begin
              tx_reg     <= bus.in_data;
              cnt        <= '0;
              in_ready_q <= 1'b0;
              sr_si_q    <= bus.in_data[WIDTH-1];
            end else begin
              state      <= IDLE;
              in_ready_q <= 1'b1;
              sr_si_q    <= 1'b0;
            end
          end else begin
            tx_reg     <= tx_reg << 1;
            cnt        <= cnt + CW'(1);
            in_ready_q <= (cnt == CW'(WIDTH - 2));
            sr_si_q    <= tx_reg[WIDTH-2];
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // mark mirrors the external register stage by stage, so its MSB qualifies sr_so.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mark        <= '0;
      rx_reg      <= '0;
      rcnt        <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      mark        <= (mark << 1) | DEPTH'(state == SEND);
      out_valid_q <= 1'b0;
      if (mark[DEPTH-1]) begin
        rx_reg <= rx_next;
        if (rx_last) begin
          rcnt        <= '0;
          out_valid_q <= 1'b1;
          out_data_q  <= rx_next;
        end else begin
          rcnt <= rcnt + CW'(1);
        end
      end
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.sr_si     = sr_si_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.busy      = (state == SEND) | (|mark) | (rcnt != '0);
  assign bus.dbg_state = state;

`ifdef RSR_CHECK_EN
  logic [WIDTH-1:0] exp_mem [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       level;
  logic             push;

  assign push = bus.in_valid & in_ready_q;

  // An empty FIFO on completion also counts as an error: a word arrived that was never sent.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) exp_mem[i] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      level  <= '0;
      err    <= 1'b0;
    end else begin
      err <= 1'b0;
      if (push) begin
        exp_mem[wr_ptr] <= bus.in_data;
        wr_ptr          <= ~wr_ptr;
      end
      if (rx_last) begin
        rd_ptr <= ~rd_ptr;
        err    <= (level == 2'd0) || (exp_mem[rd_ptr] != rx_next);
      end
      level <= level + {1'b0, push} - {1'b0, rx_last};
    end
  end
`endif

endmodule

// File: tb/tb_rsr_stream_ctrl.sv
// Directed bench for rsr_stream_ctrl with a behavioural DEPTH-stage shift register between sr_si and sr_so.
module tb_rsr_stream_ctrl;
  localparam int W = 8;
  localparam int D = 4;

  logic clk;
  logic rst_n;
  logic corrupt;
  logic [D-1:0] sr_q;
  int n_cmp;
  int n_err;
`ifdef RSR_CHECK_EN
  logic err;
`endif

  rsr_stream_ctrl_if #(.WIDTH(W)) bus ();

  rsr_stream_ctrl #(.WIDTH(W), .DEPTH(D)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef RSR_CHECK_EN
    ,
    .err   (err)
`endif
  );

  // clock/reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Non-resettable register model; starts with junk so stale bits are present.
  initial sr_q = 4'b1011;
  always @(posedge clk) sr_q <= {sr_q[D-2:0], bus.sr_si ^ corrupt};
  assign bus.sr_so = sr_q[D-1];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check1(input string tag, input int idx, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s[%0d]: observed %0b expected %0b", tag, idx, obs, exp);
    end
  endtask

  task automatic checkw(input string tag, input int idx, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s[%0d]: observed %0h expected %0h", tag, idx, obs, exp);
    end
  endtask

  task automatic check_reset_values(input int idx);
    check1("rst_in_ready", idx, bus.in_ready, 1'b1);
    check1("rst_sr_si", idx, bus.sr_si, 1'b0);
    check1("rst_out_valid", idx, bus.out_valid, 1'b0);
    checkw("rst_out_data", idx, bus.out_data, 8'h00);
    check1("rst_busy", idx, bus.busy, 1'b0);
    check1("rst_state", idx, bus.dbg_state, 1'b0);
  endtask

  // driver: one word; flip_bit >= 0 corrupts that bit (MSB-first index) inside the register model
  task automatic run_word(input logic [W-1:0] w, input int flip_bit);
    logic [W-1:0] exp_word;
    exp_word = (flip_bit >= 0) ? (w ^ (8'h80 >> flip_bit)) : w;
    bus.in_valid = 1'b1;
    bus.in_data  = w;
    tick();
    bus.in_valid = 1'b0;
    for (int c = 0; c < 15; c++) begin
      corrupt = (c == flip_bit);
      check1("word_sr_si", c, bus.sr_si, (c < W) ? w[W-1-c] : 1'b0);
      check1("word_in_ready", c, bus.in_ready, c >= W - 1);
      check1("word_state", c, bus.dbg_state, c < W);
      check1("word_out_valid", c, bus.out_valid, c == W + D);
      check1("word_busy", c, bus.busy, c < W + D);
      if (c == W + D) checkw("word_out_data", c, bus.out_data, exp_word);
`ifdef RSR_CHECK_EN
      check1("word_err", c, err, (c == W + D) && (flip_bit >= 0));
`endif
      tick();
    end
    corrupt = 1'b0;
  endtask

  // driver: two words; second in_valid raised at cycle raise_at, decoy data until cycle 6
  task automatic stream2(input logic [W-1:0] w0, input logic [W-1:0] w1, input int raise_at);
    bus.in_valid = 1'b1;
    bus.in_data  = w0;
    tick();
    if (raise_at > 0) bus.in_valid = 1'b0;
    for (int c = 0; c < 31; c++) begin
      if (c == raise_at) begin
        bus.in_valid = 1'b1;
        bus.in_data  = (raise_at == 0) ? w1 : 8'h0F;
      end
      if (c == 6) bus.in_data = w1;
      if (c == W) bus.in_valid = 1'b0;
      check1("strm_in_ready", c, bus.in_ready, (c < 2 * W) ? ((c % W) == W - 1) : 1'b1);
      check1("strm_sr_si", c, bus.sr_si,
             (c < W) ? w0[W-1-c] : (c < 2 * W) ? w1[2*W-1-c] : 1'b0);
      check1("strm_out_valid", c, bus.out_valid, (c == W + D) || (c == 2 * W + D));
      check1("strm_busy", c, bus.busy, c < 2 * W + D);
      if (c == W + D) checkw("strm_word0", c, bus.out_data, w0);
      if (c == 2 * W + D) checkw("strm_word1", c, bus.out_data, w1);
      tick();
    end
  endtask

  initial begin
    n_cmp        = 0;
    n_err        = 0;
    corrupt      = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    rst_n        = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check_reset_values(0);
    tick();
    tick();
    rst_n = 1'b1;

    // idle: filler bits only
    for (int c = 0; c < 20; c++) begin
      check1("idle_sr_si", c, bus.sr_si, 1'b0);
      check1("idle_out_valid", c, bus.out_valid, 1'b0);
      check1("idle_busy", c, bus.busy, 1'b0);
      check1("idle_in_ready", c, bus.in_ready, 1'b1);
      tick();
    end

    run_word(8'hCA, -1);
    stream2(8'hCA, 8'h35, 0);

    // reset in the middle of 0xFF, bit 3 on sr_si
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hFF;
    tick();
    bus.in_valid = 1'b0;
    tick();
    tick();
    tick();
    check1("mid_sr_si", 3, bus.sr_si, 1'b1);
    check1("mid_busy", 3, bus.busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check_reset_values(1);
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      check1("post_rst_out_valid", c, bus.out_valid, 1'b0);
      check1("post_rst_busy", c, bus.busy, 1'b0);
      tick();
    end

    run_word(8'h81, -1);
    stream2(8'hA3, 8'h55, 2);
`ifdef RSR_CHECK_EN
    run_word(8'hCA, 3);
    run_word(8'h3C, -1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
